mem_port_arbiter: RTL

//   Parametrised N-requester arbiter for the RAM data port (addr_a/data_a side); generalises the debug/CPU mux.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the RAM data-port arbiter: session FSM encoding and round-robin pointer step.
// The pointer step skips master 0, which is only ever granted inside a debug session.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        DRAIN   = 2'd1,
        DEBUG   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 1 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker over masters 1..N-1, starting at i_ptr; one-hot result.
// Zero latency; a request with no grant simply stays pending upstream.
module rr_pick #(
    parameter int N     = 3,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = i_ptr;
        for (int k = 0; k < N - 1; k++) begin
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
            // Wrap from the last master back to 1, never onto the debug master.
            w_idx = (w_idx == PTR_W'(N - 1)) ? PTR_W'(1) : w_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master arbiter for the RAM data port with a debug session that halts the CPU and owns the port.
// Grant and RAM drive are same-cycle; read data returns one cycle later; requests are held until m_gnt.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_MASTERS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BSEL_W    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dbg_req,
    output logic                          halt,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_we,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS*BSEL_W-1:0]   m_bsel,
    output logic [N_MASTERS-1:0]          m_gnt,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [DATA_W-1:0]             ram_wdata,
    output logic [BSEL_W-1:0]             ram_bsel,
    output logic                          ram_we,
    input  logic [DATA_W-1:0]             ram_rdata
);

    localparam int PTR_W = $clog2(N_MASTERS);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       r_rr_ptr;
    logic [PTR_W-1:0]       w_win_idx;
    logic [N_MASTERS-1:0]   w_rr_gnt;
    logic [N_MASTERS-1:0]   w_gnt;
    logic [N_MASTERS-1:0]   r_rvalid;
    logic                   r_halt;

    rr_pick #(
        .N     (N_MASTERS),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req (m_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rr_gnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gnt       = '0;
        case (r_state)
            NORMAL: begin
                if (dbg_req) w_state_nxt = DRAIN;
                else         w_gnt       = w_rr_gnt;
            end
            DRAIN:   w_state_nxt = DEBUG;
            DEBUG: begin
                // Master 0 still wins in the exit cycle so its last access completes.
                w_gnt[0] = m_req[0];
                if (!dbg_req) w_state_nxt = RELEASE;
            end
            RELEASE: w_state_nxt = NORMAL;
            default: w_state_nxt = NORMAL;
        endcase
        if (rst) w_gnt = '0;
    end

    always_comb begin
        w_win_idx = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_bsel  = '0;
        ram_we    = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (w_gnt[i]) begin
                w_win_idx = PTR_W'(i);
                ram_addr  = m_addr[i*ADDR_W +: ADDR_W];
                ram_wdata = m_wdata[i*DATA_W +: DATA_W];
                ram_bsel  = m_bsel[i*BSEL_W +: BSEL_W];
                ram_we    = m_we[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= NORMAL;
            r_rr_ptr <= PTR_W'(1);
            r_halt   <= 1'b0;
            r_rvalid <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_halt   <= (w_state_nxt == DEBUG);
            r_rvalid <= w_gnt & ~m_we;
            if (r_state == NORMAL && |w_gnt)
                r_rr_ptr <= PTR_W'(rr_next(int'(w_win_idx), N_MASTERS));
        end
    end

    assign m_gnt    = w_gnt;
    assign halt     = r_halt;
    // A read in flight when reset hits is dropped, not delivered.
    assign m_rvalid = rst ? '0 : r_rvalid;
    assign m_rdata  = ram_rdata;

endmodule
